// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and FSM state type for the scrubbed register file
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    SCRUB = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_cell.sv
// rtl/regfile_cell.sv - one storage word: enabled load with synchronous clear
module regfile_cell #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  // Clear wins over load so a reset cycle never commits a write
  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_scrub.sv
// rtl/regfile_scrub.sv - 2R1W register file with hardware scrub; REGFILE_BYPASS_EN adds write-to-read bypass
module regfile_scrub
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              scrub_req,
  output logic              scrub_busy,
  output logic              scrub_done
);

  localparam int                N        = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   scrub_idx;
  logic                wr_fire;
  logic                scrub_last;
  logic [N-1:1]        cell_en;
  logic [DATA_W-1:0]   cell_d;
  logic [DATA_W-1:0]   regs [N];

  assign wr_fire    = wr_valid && wr_ready;
  assign scrub_last = (state == SCRUB) && (scrub_idx == LAST_IDX);

  // FSM state register
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: a request while scrubbing is dropped, not queued
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (scrub_req) state_nxt = SCRUB;
      SCRUB:   if (scrub_idx == LAST_IDX) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: writes are only taken when idle and not in reset
  always_comb begin
    wr_ready   = (state == IDLE) && !clr;
    scrub_busy = (state == SCRUB);
  end

  // Scrub walker index and the registered completion pulse
  always_ff @(posedge clk) begin
    if (clr) begin
      scrub_idx  <= '0;
      scrub_done <= 1'b0;
    end else begin
      scrub_done <= scrub_last;
      if (state == IDLE && scrub_req) begin
        scrub_idx <= ADDR_W'(1);
      end else if (scrub_last) begin
        scrub_idx <= '0;
      end else if (state == SCRUB) begin
        scrub_idx <= scrub_idx + ADDR_W'(1);
      end
    end
  end

  // One-hot cell enable; scrub shares the write path with data forced to zero
  always_comb begin
    cell_d  = wr_data;
    cell_en = '0;
    for (int i = 1; i < N; i++) begin
      if (state == SCRUB) begin
        cell_en[i] = (scrub_idx == ADDR_W'(i));
      end else begin
        cell_en[i] = wr_fire && (wr_addr == ADDR_W'(i));
      end
    end
    if (state == SCRUB) begin
      cell_d = '0;
    end
  end

  assign regs[0] = '0;

  for (genvar g = 1; g < N; g++) begin : g_cell
    regfile_cell #(
      .DATA_W (DATA_W)
    ) u_cell (
      .clk (clk),
      .clr (clr),
      .en  (cell_en[g]),
      .d   (cell_d),
      .q   (regs[g])
    );
  end

  // Combinational read ports, optionally forwarding the write accepted this cycle
  always_comb begin
    rd_data_a = regs[rd_addr_a];
    rd_data_b = regs[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
    if (wr_fire && wr_addr != '0) begin
      if (rd_addr_a == wr_addr) rd_data_a = wr_data;
      if (rd_addr_b == wr_addr) rd_data_b = wr_data;
    end
`else
`endif
  end

endmodule

// File: doc/regfile_scrub.md
REGFILE_SCRUB -- requirements
Module: regfile_scrub

Interface
- REQ-001: Parameter DATA_W, default 32, width of each register and data port.
- REQ-002: Parameter ADDR_W, default 5, address width; register count is 2**ADDR_W.
- REQ-003: clk  input  1  single clock; all state updates on posedge clk.
- REQ-004: clr  input  1  reset, synchronous and active-high.
- REQ-005: wr_valid  input  1  write request present.
- REQ-006: wr_ready  output  1  block accepts a write this cycle.
- REQ-007: wr_addr  input  ADDR_W  destination register.
- REQ-008: wr_data  input  DATA_W  write data.
- REQ-009: rd_addr_a / rd_addr_b  input  ADDR_W  read port A/B addresses.
- REQ-010: rd_data_a / rd_data_b  output  DATA_W  read port A/B data.
- REQ-011: scrub_req  input  1  request to zero registers 1..N-1.
- REQ-012: scrub_busy  output  1  scrub sequence in progress.
- REQ-013: scrub_done  output  1  one-cycle pulse when scrub completes.

Function
- REQ-014: Write handshake: a write is accepted when wr_valid && wr_ready at a posedge clk, and the addressed register takes wr_data at that edge.
- REQ-015: Write to address 0: the handshake completes and register 0 is unchanged (always 0).
- REQ-016: Reads are combinational from stored values; address 0 reads 0; a write is visible on reads the cycle after acceptance (unless bypass is compiled in, REQ-027).
- REQ-017: wr_ready = (state == IDLE) && !clr; wr_ready is combinational, not registered.
- REQ-018: FSM states are IDLE and SCRUB.
- REQ-019: IDLE -> SCRUB on an edge with scrub_req=1; scrub_idx is loaded with 1.
- REQ-020: In SCRUB, each edge zeros register[scrub_idx] and increments scrub_idx; at the edge where scrub_idx == N-1, that register is zeroed and the FSM returns to IDLE.
- REQ-021: The scrub takes exactly N-1 cycles (31 at default); scrub_busy = (state == SCRUB).
- REQ-022: scrub_done is registered and is high for exactly the one cycle after the final scrub edge.
- REQ-023: scrub_req in SCRUB is ignored (not queued).
- REQ-024: scrub_req and an accepted write in the same IDLE cycle: the write commits at that edge; the scrub starts at that same edge and later zeros the written register.
- REQ-025: Reads stay valid during SCRUB and show partially scrubbed contents.

Reset
- REQ-026: clr=1 at an edge sets all registers to 0, FSM to IDLE, scrub_idx to 0 and scrub_done to 0; clr during SCRUB aborts the scrub with no scrub_done pulse; clr overrides any write in the same cycle.

Configuration
- REQ-027: With REGFILE_BYPASS_EN defined, a read whose address equals wr_addr (nonzero) while a write is accepted that cycle returns wr_data combinationally; without the macro, reads return only stored values.

Structure
- REQ-028: Package regfile_pkg holds DATA_W/ADDR_W defaults and the FSM state enum (IDLE, SCRUB).
- REQ-029: Storage uses N-1 instances of one sub-module, regfile_cell (DATA_W enable register with synchronous clear); register 0 is a constant 0, not a cell.
- REQ-030: Write decode generates a one-hot cell enable; scrub uses the same enable path with data forced to 0.

Verification
- REQ-031: Write 0xDEADBEEF to r5 -> the next cycle rd_addr_a=5 returns 0xDEADBEEF and rd_addr_b=0 returns 0.
- REQ-032: Write 0x12345678 to r0 -> wr_ready=1 and the handshake completes; reading r0 returns 0.
- REQ-033: Fill r1..r31 with their index, pulse scrub_req -> scrub_busy is high for 31 cycles, scrub_done pulses once, all reads return 0, and wr_valid is stalled throughout.
- REQ-034: Assert clr at scrub cycle 10 -> FSM returns to IDLE, no scrub_done pulse, all registers 0, and wr_ready is 1 the cycle after clr falls.
- REQ-035: With REGFILE_BYPASS_EN, write 0xA5A5A5A5 to r7 while rd_addr_a=7 -> rd_data_a=0xA5A5A5A5 in the same cycle; without the macro, the prior value is returned.
- REQ-036: scrub_req and a write of 0x55 to r3 in the same cycle -> r3 reads 0x55 until scrub cycle 3, then 0.
